// File: rtl/gat_pkg.sv
// Shared types for the GAT layer scheduler: FSM state encoding and default watchdog limit.
package gat_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOAD = 3'd1,
        S_START     = 3'd2,
        S_RUN       = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } sched_state_e;

    localparam int TIMEOUT_CYC_DEFAULT = 2 ** 24;

endpackage

// File: rtl/gat_layer_scheduler_if.sv
// Control/status bundle between the register bank, the layer scheduler and the core top.
interface gat_layer_scheduler_if #(
    parameter int TOP_WIDTH = 32,
    parameter int LAYER_W   = 1
);
    logic                 sched_start;
    logic                 h_data_load_done;
    logic                 h_node_load_done;
    logic                 wgt_load_done;
    logic                 core_done;
    logic                 core_start;
    logic [LAYER_W-1:0]   core_layer;
    logic                 wgt_reload_req;
    logic                 sched_busy;
    logic                 sched_done;
    logic                 sched_err;
    logic [TOP_WIDTH-1:0] layer_cycles;
    logic [2:0]           dbg_state;

    modport master (
        output sched_start, h_data_load_done, h_node_load_done, wgt_load_done, core_done,
        input  core_start, core_layer, wgt_reload_req, sched_busy, sched_done, sched_err,
               layer_cycles, dbg_state
    );

    modport slave (
        input  sched_start, h_data_load_done, h_node_load_done, wgt_load_done, core_done,
        output core_start, core_layer, wgt_reload_req, sched_busy, sched_done, sched_err,
               layer_cycles, dbg_state
    );
endinterface

// File: rtl/gat_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module gat_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/gat_layer_scheduler.sv
// Runs the GAT core through NUM_LAYERS layers per software start, gating each layer on
// BRAM-load flags, timing each layer and aborting hung phases through a watchdog.
module gat_layer_scheduler
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH   = 32,
    parameter int NUM_LAYERS  = 2,
    parameter int LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    gat_layer_scheduler_if.slave bus
);

    localparam int                 WD_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    sched_state_e         state;
    logic [LAYER_W-1:0]   layer;
    logic                 wgt_seen_low;
    logic                 core_start_q;
    logic                 reload_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [TOP_WIDTH-1:0] layer_cycles_q;

    logic [TOP_WIDTH-1:0] cyc;
    logic [TOP_WIDTH-1:0] cyc_inc;
    logic [WD_W-1:0]      wd;
    logic                 wd_active;
    logic                 wd_expired;
    logic                 load_ready;

    // The watchdog only runs in the two waiting states; any other state clears it,
    // so every entry into WAIT_LOAD or RUN starts from zero.
    assign wd_active  = (state == S_WAIT_LOAD) || (state == S_RUN);
    assign wd_expired = (wd == WD_LAST);
    assign cyc_inc    = (&cyc) ? cyc : cyc + TOP_WIDTH'(1);

    // Layer 0 needs every buffer loaded; later layers only need a fresh weight load.
    assign load_ready = (layer == '0)
        ? (bus.h_data_load_done && bus.h_node_load_done && bus.wgt_load_done)
        : (wgt_seen_low && bus.wgt_load_done);

    gat_sat_counter #(.WIDTH(TOP_WIDTH)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != S_RUN),
        .en    (state == S_RUN),
        .count (cyc)
    );

    gat_sat_counter #(.WIDTH(WD_W)) u_wd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!wd_active),
        .en    (wd_active),
        .count (wd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            layer          <= '0;
            wgt_seen_low   <= 1'b0;
            core_start_q   <= 1'b0;
            reload_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            layer_cycles_q <= '0;
        end else begin
            // NOTE: non-blocking default; the START branch overrides it, so the pulse
            // lasts exactly one cycle without a separate clear path.
            core_start_q <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.sched_start) begin
                        state        <= S_WAIT_LOAD;
                        layer        <= '0;
                        wgt_seen_low <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                    end
                end
                S_WAIT_LOAD: begin
                    if (!bus.wgt_load_done) wgt_seen_low <= 1'b1;
                    if (load_ready) begin
                        state        <= S_START;
                        core_start_q <= 1'b1;
                        reload_q     <= 1'b0;
                    end else if (wd_expired) begin
                        state    <= S_ERR;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        reload_q <= 1'b0;
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    // A completion seen on the expiry cycle still counts as success.
                    if (bus.core_done) begin
                        layer_cycles_q <= cyc_inc;
                        if (layer == LAST_LAYER) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (wd_expired) begin
                        state  <= S_ERR;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                S_NEXT: begin
                    state        <= S_WAIT_LOAD;
                    layer        <= layer + LAYER_W'(1);
                    wgt_seen_low <= 1'b0;
                    reload_q     <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_start     = core_start_q;
    assign bus.core_layer     = layer;
    assign bus.wgt_reload_req = reload_q;
    assign bus.sched_busy     = busy_q;
    assign bus.sched_done     = done_q;
    assign bus.sched_err      = err_q;
    assign bus.layer_cycles   = layer_cycles_q;
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Self-checking bench: three scheduler instances (long timeout, 64-cycle timeout, single layer)
// share one stimulus stream; core_start events are matched against a queue of expected layers.
module tb_gat_layer_scheduler;
    import gat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gat_layer_scheduler_if #(.TOP_WIDTH(32), .LAYER_W(1)) bus_a ();
    gat_layer_scheduler_if #(.TOP_WIDTH(32), .LAYER_W(1)) bus_b ();
    gat_layer_scheduler_if #(.TOP_WIDTH(32), .LAYER_W(1)) bus_c ();

    assign bus_b.sched_start      = bus_a.sched_start;
    assign bus_b.h_data_load_done = bus_a.h_data_load_done;
    assign bus_b.h_node_load_done = bus_a.h_node_load_done;
    assign bus_b.wgt_load_done    = bus_a.wgt_load_done;
    assign bus_b.core_done        = bus_a.core_done;
    assign bus_c.sched_start      = bus_a.sched_start;
    assign bus_c.h_data_load_done = bus_a.h_data_load_done;
    assign bus_c.h_node_load_done = bus_a.h_node_load_done;
    assign bus_c.wgt_load_done    = bus_a.wgt_load_done;
    assign bus_c.core_done        = bus_a.core_done;

    gat_layer_scheduler #(.TOP_WIDTH(32), .NUM_LAYERS(2), .LAYER_W(1), .TIMEOUT_CYC(1024))
        dut (.clk(clk), .rst(rst), .bus(bus_a));
    gat_layer_scheduler #(.TOP_WIDTH(32), .NUM_LAYERS(2), .LAYER_W(1), .TIMEOUT_CYC(64))
        dut_wd (.clk(clk), .rst(rst), .bus(bus_b));
    gat_layer_scheduler #(.TOP_WIDTH(32), .NUM_LAYERS(1), .LAYER_W(1), .TIMEOUT_CYC(1024))
        dut_one (.clk(clk), .rst(rst), .bus(bus_c));

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];
    logic prev_cs = 1'b0;
    logic c_reload_seen = 1'b0;

    typedef struct {
        logic         h;
        logic         wgt;
        logic         cdone;
        logic         start;
        logic         push;
        sched_state_e st;
        logic         cs;
        logic         rl;
        logic         busy;
        logic         done;
        logic [31:0]  lc;
    } step_t;

    step_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"},  32'(bus_a.dbg_state), 32'(S_IDLE));
        check({tag, "_cs"},     32'(bus_a.core_start), 0);
        check({tag, "_layer"},  32'(bus_a.core_layer), 0);
        check({tag, "_reload"}, 32'(bus_a.wgt_reload_req), 0);
        check({tag, "_busy"},   32'(bus_a.sched_busy), 0);
        check({tag, "_done"},   32'(bus_a.sched_done), 0);
        check({tag, "_err"},    32'(bus_a.sched_err), 0);
        check({tag, "_lc"},     bus_a.layer_cycles, 0);
    endtask

    task automatic pulse_start();
        bus_a.sched_start = 1'b1;
        @(negedge clk);
        bus_a.sched_start = 1'b0;
    endtask

    task automatic wait_state_a(input string name, input sched_state_e s, input int limit);
        int n;
        n = 0;
        while (bus_a.dbg_state != s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus_a.dbg_state), 32'(s));
    endtask

    // Scoreboard for core_start on the main instance, plus spacing and single-layer monitors.
    always @(negedge clk) begin
        if (bus_a.core_start) begin
            check("core_start_gap", 32'(prev_cs), 0);
            check("core_start_expected", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check("core_start_layer", 32'(bus_a.core_layer), sb_q.pop_front());
        end
        prev_cs = bus_a.core_start;
        if (bus_c.wgt_reload_req) c_reload_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{h:0, wgt:0, cdone:0, start:0, push:0, st:S_WAIT_LOAD, cs:0, rl:1, busy:1, done:0, lc:100};
        tbl[1] = '{h:0, wgt:0, cdone:1, start:0, push:0, st:S_WAIT_LOAD, cs:0, rl:1, busy:1, done:0, lc:100};
        tbl[2] = '{h:0, wgt:1, cdone:0, start:0, push:1, st:S_START,     cs:1, rl:0, busy:1, done:0, lc:100};
        tbl[3] = '{h:0, wgt:1, cdone:0, start:0, push:0, st:S_RUN,       cs:0, rl:0, busy:1, done:0, lc:100};
        tbl[4] = '{h:0, wgt:1, cdone:0, start:1, push:0, st:S_RUN,       cs:0, rl:0, busy:1, done:0, lc:100};
        tbl[5] = '{h:0, wgt:1, cdone:1, start:0, push:0, st:S_DONE,      cs:0, rl:0, busy:0, done:1, lc:2};
        tbl[6] = '{h:0, wgt:1, cdone:0, start:0, push:0, st:S_DONE,      cs:0, rl:0, busy:0, done:1, lc:2};

        bus_a.sched_start      = 1'b0;
        bus_a.h_data_load_done = 1'b0;
        bus_a.h_node_load_done = 1'b0;
        bus_a.wgt_load_done    = 1'b0;
        bus_a.core_done        = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // Layer 0: flags ready before the start pulse, core_done on RUN cycle 100.
        bus_a.h_data_load_done = 1'b1;
        bus_a.h_node_load_done = 1'b1;
        bus_a.wgt_load_done    = 1'b1;
        sb_q.push_back(0);
        pulse_start();
        check("t1_wait_state", 32'(bus_a.dbg_state), 32'(S_WAIT_LOAD));
        check("t1_no_cs_yet", 32'(bus_a.core_start), 0);
        check("t1_busy", 32'(bus_a.sched_busy), 1);
        @(negedge clk);
        check("t1_cs", 32'(bus_a.core_start), 1);
        check("t1_cs_layer", 32'(bus_a.core_layer), 0);
        @(negedge clk);
        check("t1_run", 32'(bus_a.dbg_state), 32'(S_RUN));
        check("t1_cs_low", 32'(bus_a.core_start), 0);
        repeat (99) @(negedge clk);
        bus_a.core_done = 1'b1;
        @(negedge clk);
        bus_a.core_done = 1'b0;
        check("t1_layer_cycles", bus_a.layer_cycles, 100);
        check("t1_next", 32'(bus_a.dbg_state), 32'(S_NEXT));
        check("one_done", 32'(bus_c.sched_done), 1);
        check("one_busy", 32'(bus_c.sched_busy), 0);
        check("one_lc", bus_c.layer_cycles, 100);
        @(negedge clk);
        check("t1_reload", 32'(bus_a.wgt_reload_req), 1);
        check("t1_layer1", 32'(bus_a.core_layer), 1);

        // Layer 1 with the weight flag stuck high must not start the core.
        repeat (10) @(negedge clk);
        check("t2_stuck_state", 32'(bus_a.dbg_state), 32'(S_WAIT_LOAD));
        for (int i = 0; i < 7; i++) begin
            bus_a.h_data_load_done = tbl[i].h;
            bus_a.wgt_load_done    = tbl[i].wgt;
            bus_a.core_done        = tbl[i].cdone;
            bus_a.sched_start      = tbl[i].start;
            if (tbl[i].push) sb_q.push_back(1);
            @(negedge clk);
            check($sformatf("t2_step%0d_state", i), 32'(bus_a.dbg_state), 32'(tbl[i].st));
            check($sformatf("t2_step%0d_cs", i), 32'(bus_a.core_start), 32'(tbl[i].cs));
            check($sformatf("t2_step%0d_reload", i), 32'(bus_a.wgt_reload_req), 32'(tbl[i].rl));
            check($sformatf("t2_step%0d_busy", i), 32'(bus_a.sched_busy), 32'(tbl[i].busy));
            check($sformatf("t2_step%0d_done", i), 32'(bus_a.sched_done), 32'(tbl[i].done));
            check($sformatf("t2_step%0d_lc", i), bus_a.layer_cycles, tbl[i].lc);
            check($sformatf("t2_step%0d_layer", i), 32'(bus_a.core_layer), 1);
        end
        bus_a.core_done   = 1'b0;
        bus_a.sched_start = 1'b0;

        // Watchdog expiry 64 cycles after RUN entry on the short-timeout instance.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_a.h_data_load_done = 1'b1;
        bus_a.h_node_load_done = 1'b1;
        bus_a.wgt_load_done    = 1'b1;
        sb_q.push_back(0);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("t3_run_entry", 32'(bus_b.dbg_state), 32'(S_RUN));
        repeat (63) @(negedge clk);
        check("t3_err_not_yet", 32'(bus_b.sched_err), 0);
        check("t3_still_run", 32'(bus_b.dbg_state), 32'(S_RUN));
        @(negedge clk);
        check("t3_err", 32'(bus_b.sched_err), 1);
        check("t3_err_state", 32'(bus_b.dbg_state), 32'(S_ERR));
        check("t3_err_busy", 32'(bus_b.sched_busy), 0);
        pulse_start();
        check("t3_err_cleared", 32'(bus_b.sched_err), 0);
        check("t3_restart", 32'(bus_b.dbg_state), 32'(S_WAIT_LOAD));
        check("t4_start_ignored", 32'(bus_a.dbg_state), 32'(S_RUN));

        // core_done on the exact expiry cycle completes the layer instead of erroring.
        @(negedge clk);
        @(negedge clk);
        check("t6_run_entry", 32'(bus_b.dbg_state), 32'(S_RUN));
        repeat (63) @(negedge clk);
        bus_a.core_done = 1'b1;
        @(negedge clk);
        bus_a.core_done = 1'b0;
        check("t6_no_err", 32'(bus_b.sched_err), 0);
        check("t6_next", 32'(bus_b.dbg_state), 32'(S_NEXT));
        check("t6_lc", bus_b.layer_cycles, 64);

        // Reset in the middle of RUN, then a complete two-layer run.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(0);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("t5_run", 32'(bus_a.dbg_state), 32'(S_RUN));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("t5_midrun");
        @(negedge clk);
        check("t5_stays_idle", 32'(bus_a.dbg_state), 32'(S_IDLE));
        sb_q.push_back(0);
        pulse_start();
        wait_state_a("t5_l0_run", S_RUN, 5);
        bus_a.core_done = 1'b1;
        @(negedge clk);
        bus_a.core_done = 1'b0;
        wait_state_a("t5_l1_wait", S_WAIT_LOAD, 5);
        bus_a.wgt_load_done = 1'b0;
        @(negedge clk);
        bus_a.wgt_load_done = 1'b1;
        sb_q.push_back(1);
        wait_state_a("t5_l1_run", S_RUN, 5);
        bus_a.core_done = 1'b1;
        @(negedge clk);
        bus_a.core_done = 1'b0;
        check("t5_done", 32'(bus_a.sched_done), 1);
        check("t5_busy", 32'(bus_a.sched_busy), 0);
        check("t5_last_layer", 32'(bus_a.core_layer), 1);
        @(negedge clk);

        check("sb_drained", 32'(sb_q.size()), 0);
        check("one_never_reload", 32'(c_reload_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
